codificador_prioridad_reg: RTL and testbench

//  Registered priority encoder: inverse of the 1-of-N active-low line decoders.

---
 rtl/codificador_prioridad_reg_if.sv | 25 ++
 rtl/codificador_prioridad_reg.sv | 137 +++++++++++++
 tb/tb_codificador_prioridad_reg.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/codificador_prioridad_reg_if.sv
// Request/index bus for the registered priority encoder.
// The master side drives the active-low request lines, enable and ack.
// The slave side (the encoder) returns the index and the status flags.
interface codificador_prioridad_reg_if #(
    parameter int N = 16,
    parameter int W = 4
);
    logic         en;
    logic [N-1:0] a;
    logic         ack;
    logic [W-1:0] b;
    logic         valid;
    logic         busy;
    logic         mult;

    modport master (
        output en, a, ack,
        input  b, valid, busy, mult
    );

    modport slave (
        input  en, a, ack,
        output b, valid, busy, mult
    );
endinterface

// File: rtl/codificador_prioridad_reg.sv
// Registered priority encoder for active-low request lines.
// Synchronises a[], captures the lowest-numbered active line into b and
// holds it behind a valid/ack handshake. After ack, it waits until every
// line is released before it can capture again.
// Optional feature: define ENC_MULTI_ERR_EN to flag captures where more
// than one line was active (mult). Without it, mult stays 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for an enabled request on the synchronised lines
// HOLD    | index captured, valid high, waiting for ack
// RELEASE | index consumed, waiting for all lines to go inactive
module codificador_prioridad_reg #(
    parameter int N           = 16,
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    codificador_prioridad_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]                  s;
    logic [W-1:0]                  enc_idx;
    logic                          any_req;
    logic                          all_free;
    logic                          multi;

    state_t     state_q, state_d;
    logic [W-1:0] b_q, b_d;
    logic       valid_q, valid_d;
    logic       mult_q, mult_d;

    // Synchroniser chain; resets to all ones so no line looks active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.a};
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign any_req  = ~&s;
    assign all_free = &s;

    // Lowest-numbered active line wins; the descending loop lets it overwrite.
    always_comb begin
        enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!s[i]) begin
                enc_idx = W'(i);
            end
        end
    end

`ifdef ENC_MULTI_ERR_EN
    // Clearing the lowest active bit leaves something only if two or more were active.
    assign multi = |(~s & (~s - N'(1)));
`else
    assign multi = 1'b0;
`endif

    // Next-state and output-register decode; en=1 overrides everything except b.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        valid_d = valid_q;
        mult_d  = mult_q;
        if (bus.en) begin
            state_d = IDLE;
            valid_d = 1'b0;
            mult_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    mult_d  = 1'b0;
                    if (any_req) begin
                        b_d     = enc_idx;
                        valid_d = 1'b1;
                        mult_d  = multi;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    valid_d = 1'b1;
                    if (bus.ack) begin
                        valid_d = 1'b0;
                        mult_d  = 1'b0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    valid_d = 1'b0;
                    mult_d  = 1'b0;
                    if (all_free) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    mult_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            valid_q <= 1'b0;
            mult_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            mult_q  <= mult_d;
        end
    end

    assign bus.b     = b_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q == HOLD) || (state_q == RELEASE);
    assign bus.mult  = mult_q;

endmodule

// File: tb/tb_codificador_prioridad_reg.sv
// Self-checking bench for codificador_prioridad_reg.
// Stimulus pushes the expected capture into a scoreboard queue; a monitor
// pops and compares on every rising edge of valid.
module tb_codificador_prioridad_reg;

    localparam int N = 16;
    localparam int W = 4;
`ifdef ENC_MULTI_ERR_EN
    localparam bit MULTI_EN = 1'b1;
`else
    localparam bit MULTI_EN = 1'b0;
`endif

    typedef struct {
        int idx;
        int mult;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    codificador_prioridad_reg_if #(.N(N), .W(W)) bus_if ();

    codificador_prioridad_reg #(.N(N), .W(W), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lowest index holding a 0, and whether more than one 0 exists.
    function automatic exp_t model(input logic [N-1:0] pat);
        exp_t e;
        e.idx = -1;
        for (int i = 0; i < N; i++) begin
            if (pat[i] == 1'b0 && e.idx < 0) e.idx = i;
        end
        e.mult = (MULTI_EN && $countones(~pat) > 1) ? 1 : 0;
        return e;
    endfunction

    // Monitor: compare each fresh valid against the scoreboard.
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && bus_if.valid && !valid_prev) begin
            check("b_known", int'($isunknown(bus_if.b)), 0);
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_b", int'(bus_if.b), e.idx);
                check("sb_mult", int'(bus_if.mult), e.mult);
                check("sb_busy", int'(bus_if.busy), 1);
            end
        end
        valid_prev = bus_if.valid;
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus_if.valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(bus_if.valid), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus_if.busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(bus_if.busy), 0);
    endtask

    // Full transaction: request, hold for ack_delay cycles, ack, release.
    task automatic do_capture(input logic [N-1:0] pat, input int ack_delay);
        bus_if.a = pat;
        sb.push_back(model(pat));
        wait_valid("cap_valid");
        repeat (ack_delay) @(negedge clk);
        check("hold_valid", int'(bus_if.valid), 1);
        bus_if.ack = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0;
        check("ack_drop", int'(bus_if.valid), 0);
        check("ack_mult", int'(bus_if.mult), 0);
        bus_if.a = '1;
        wait_idle("cap_idle");
    endtask

    initial begin
        logic [N-1:0] pat;
        int           hold_b;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.en  = 1'b1;
        bus_if.a   = '1;
        bus_if.ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_b", int'(bus_if.b), 0);
        check("rst_valid", int'(bus_if.valid), 0);
        check("rst_busy", int'(bus_if.busy), 0);
        check("rst_mult", int'(bus_if.mult), 0);
        rst = 1'b0;
        bus_if.en = 1'b0;
        repeat (2) @(negedge clk);

        // Latency: line 5 -> valid on the 3rd edge.
        bus_if.a = 16'hFFDF;
        sb.push_back(model(16'hFFDF));
        @(negedge clk);
        check("lat_e1", int'(bus_if.valid), 0);
        @(negedge clk);
        check("lat_e2", int'(bus_if.valid), 0);
        @(negedge clk);
        check("lat_e3", int'(bus_if.valid), 1);
        check("lat_b", int'(bus_if.b), 5);
        bus_if.ack = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0;
        check("lat_ack", int'(bus_if.valid), 0);
        check("rel_busy", int'(bus_if.busy), 1);
        // Held line must not re-capture.
        repeat (6) @(negedge clk);
        check("held_no_valid", int'(bus_if.valid), 0);
        check("held_busy", int'(bus_if.busy), 1);
        bus_if.a = '1;
        wait_idle("held_idle");
        do_capture(16'hFFF7, 0);

        // Multiple lines, boundary indices.
        do_capture(16'hFF5F, 1);
        do_capture(16'h7FFF, 0);
        do_capture(16'hFFFE, 2);
        do_capture(16'h0000, 0);

        // en=1 and ack=1 together in HOLD.
        bus_if.a = 16'hFBFF;
        sb.push_back(model(16'hFBFF));
        wait_valid("en_valid");
        bus_if.en  = 1'b1;
        bus_if.ack = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0;
        bus_if.a   = '1;
        check("en_valid0", int'(bus_if.valid), 0);
        check("en_busy0", int'(bus_if.busy), 0);
        check("en_b_keep", int'(bus_if.b), 10);
        check("en_mult0", int'(bus_if.mult), 0);
        bus_if.a = 16'hFFEF;
        repeat (4) @(negedge clk);
        check("en_block", int'(bus_if.valid), 0);
        bus_if.a = '1;
        repeat (4) @(negedge clk);
        bus_if.en = 1'b0;
        repeat (2) @(negedge clk);

        // Glitch straddling one rising edge: exactly one capture.
        #3 bus_if.a[9] = 1'b0;
        #4 bus_if.a[9] = 1'b1;
        sb.push_back(model(16'hFDFF));
        wait_valid("glitch_valid");
        bus_if.ack = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0;
        wait_idle("glitch_idle");
        // Glitch between edges: never sampled.
        #1 bus_if.a[2] = 1'b0;
        #2 bus_if.a[2] = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_none", int'(bus_if.valid), 0);

        // Randomized transactions.
        for (int k = 0; k < 30; k++) begin
            pat = N'($urandom_range(0, 65535));
            if ((pat | N'($urandom)) == '1 && $urandom_range(0, 1) == 1) pat = pat | N'($urandom);
            if (pat == '1) pat[$urandom_range(0, N - 1)] = 1'b0;
            do_capture(pat, int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in HOLD.
        bus_if.a = 16'hFFBF;
        sb.push_back(model(16'hFFBF));
        wait_valid("rst_hold_valid");
        #1 rst = 1'b1;
        #1;
        check("arst_b", int'(bus_if.b), 0);
        check("arst_valid", int'(bus_if.valid), 0);
        check("arst_busy", int'(bus_if.busy), 0);
        bus_if.a = '1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_valid", int'(bus_if.valid), 0);

        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
